// File: rtl/dogm132_spi_rx.sv
// Receive-side model of the DOGM132 serial display link: deserialises SPI bytes, tracks page/column/display-on
// and emits frame-buffer writes. Define DOGM132_RX_READBACK_EN to add the internal 132x32 frame buffer for readback.
module dogm132_spi_rx #(
    parameter int COLS  = 132,
    parameter int PAGES = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       disp_cs_n_i,
    input  logic       disp_res_n_i,
    input  logic       disp_data_i,
    input  logic       disp_addr_i,
    input  logic       disp_sck_i,
    output logic [7:0] byte_o,
    output logic       byte_is_data_o,
    output logic       byte_valid_o,
    output logic       fb_we_o,
    output logic [9:0] fb_addr_o,
    output logic [7:0] fb_data_o,
    output logic       disp_on_o,
    input  logic [9:0] rd_addr_i,
    output logic [7:0] rd_data_o
);
    localparam logic [8:0] ColsW = 9'(COLS);

    logic sck_s1_q, sck_s2_q, sck_s3_q;
    logic cs_s1_q, cs_s2_q, res_s1_q, res_s2_q;
    logic data_s1_q, data_s2_q, addr_s1_q, addr_s2_q;
    logic sck_rise;

    // Synchronisers: idle levels are deselected, out of display reset, SCK low.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_s3_q  <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            res_s1_q  <= 1'b1;
            res_s2_q  <= 1'b1;
            data_s1_q <= 1'b0;
            data_s2_q <= 1'b0;
            addr_s1_q <= 1'b0;
            addr_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= disp_sck_i;
            sck_s2_q  <= sck_s1_q;
            sck_s3_q  <= sck_s2_q;
            cs_s1_q   <= disp_cs_n_i;
            cs_s2_q   <= cs_s1_q;
            res_s1_q  <= disp_res_n_i;
            res_s2_q  <= res_s1_q;
            data_s1_q <= disp_data_i;
            data_s2_q <= data_s1_q;
            addr_s1_q <= disp_addr_i;
            addr_s2_q <= addr_s1_q;
        end
    end

    assign sck_rise = sck_s2_q & ~sck_s3_q;

    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q;
    logic       done_p0_q, is_data_p0_q;

    assign shift_d = {shift_q[6:0], data_s2_q};

    // Stage p0: bit shifting; done_p0_q marks a complete byte sitting in shift_q.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            done_p0_q    <= 1'b0;
            is_data_p0_q <= 1'b0;
        end else begin
            done_p0_q <= 1'b0;
            if (!res_s2_q || cs_s2_q) begin
                bit_cnt_q <= 3'd0;
            end else if (sck_rise) begin
                shift_q   <= shift_d;
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    done_p0_q    <= 1'b1;
                    is_data_p0_q <= addr_s2_q;
                end
            end
        end
    end

    logic [1:0] page_q;
    logic [7:0] col_q;
    logic [7:0] byte_q, fb_data_q;
    logic [9:0] fb_addr_q;
    logic       byte_is_data_q, byte_valid_q, fb_we_q, disp_on_q;

    // Stage p1: decode the byte into strobes, frame-buffer writes and addressing state.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            page_q         <= 2'd0;
            col_q          <= 8'd0;
            byte_q         <= 8'h00;
            byte_is_data_q <= 1'b0;
            byte_valid_q   <= 1'b0;
            fb_we_q        <= 1'b0;
            fb_addr_q      <= 10'd0;
            fb_data_q      <= 8'h00;
            disp_on_q      <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            fb_we_q      <= 1'b0;
            if (!res_s2_q) begin
                page_q    <= 2'd0;
                col_q     <= 8'd0;
                disp_on_q <= 1'b0;
            end else if (done_p0_q) begin
                byte_q         <= shift_q;
                byte_is_data_q <= is_data_p0_q;
                byte_valid_q   <= 1'b1;
                if (is_data_p0_q) begin
                    // Columns beyond the panel swallow the write but still advance, wrapping at 255.
                    if ({1'b0, col_q} < ColsW) begin
                        fb_we_q   <= 1'b1;
                        fb_addr_q <= {page_q, col_q};
                        fb_data_q <= shift_q;
                        col_q     <= ({1'b0, col_q} == ColsW - 9'd1) ? 8'd0 : col_q + 8'd1;
                    end else begin
                        col_q <= col_q + 8'd1;
                    end
                end else if (shift_q[7:2] == 6'b1011_00) begin
                    page_q <= shift_q[1:0];
                end else if (shift_q[7:4] == 4'h1) begin
                    col_q[7:4] <= shift_q[3:0];
                end else if (shift_q[7:4] == 4'h0) begin
                    col_q[3:0] <= shift_q[3:0];
                end else if (shift_q == 8'hAF) begin
                    disp_on_q <= 1'b1;
                end else if (shift_q == 8'hAE) begin
                    disp_on_q <= 1'b0;
                end
            end
        end
    end

    assign byte_o         = byte_q;
    assign byte_is_data_o = byte_is_data_q;
    assign byte_valid_o   = byte_valid_q;
    assign fb_we_o        = fb_we_q;
    assign fb_addr_o      = fb_addr_q;
    assign fb_data_o      = fb_data_q;
    assign disp_on_o      = disp_on_q;

`ifdef DOGM132_RX_READBACK_EN
    localparam int FbDepth = COLS * PAGES;

    logic [7:0] fb_mem_q [FbDepth];
    logic [7:0] rd_data_q;
    logic [9:0] wr_idx, rd_idx;

    assign wr_idx = 10'(fb_addr_q[9:8]) * 10'(COLS) + 10'(fb_addr_q[7:0]);
    assign rd_idx = 10'(rd_addr_i[9:8]) * 10'(COLS) + 10'(rd_addr_i[7:0]);

    always_ff @(posedge clk_in) begin
        if (fb_we_q) begin
            fb_mem_q[wr_idx] <= fb_data_q;
        end
    end

    // Read sees the pre-write contents when a write hits the same address this cycle.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            rd_data_q <= 8'h00;
        end else if ({1'b0, rd_addr_i[7:0]} >= ColsW) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= fb_mem_q[rd_idx];
        end
    end

    assign rd_data_o = rd_data_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr_i, 10'(COLS * PAGES)};
    assign rd_data_o = 8'h00;
`endif

endmodule

// File: tb/tb_dogm132_spi_rx.sv
// Self-checking bench for dogm132_spi_rx: directed vector table, multi-cycle corner sequences and a
// randomized byte stream compared against a behavioural panel model.
module tb_dogm132_spi_rx;
    localparam int COLS = 132;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, cs_n, res_n, sdi, a0, sck;
    logic [9:0] rd_addr;
    logic [7:0] byte_o, fb_data_o, rd_data_o;
    logic       byte_is_data_o, byte_valid_o, fb_we_o, disp_on_o;
    logic [9:0] fb_addr_o;

    dogm132_spi_rx #(.COLS(COLS), .PAGES(4)) dut (
        .clk_in(clk), .reset_in(rst), .disp_cs_n_i(cs_n), .disp_res_n_i(res_n),
        .disp_data_i(sdi), .disp_addr_i(a0), .disp_sck_i(sck),
        .byte_o(byte_o), .byte_is_data_o(byte_is_data_o), .byte_valid_o(byte_valid_o),
        .fb_we_o(fb_we_o), .fb_addr_o(fb_addr_o), .fb_data_o(fb_data_o), .disp_on_o(disp_on_o),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data_o)
    );

    int checks = 0;
    int errors = 0;
    int hp_lo = 4;
    int hp_hi = 4;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, got, want);
        end
    endtask

    // Strobe monitor
    int          n_valid = 0;
    int          n_we = 0;
    logic [7:0]  last_byte = 8'h00;
    logic        last_isd = 1'b0;
    logic [9:0]  last_addr = 10'd0;
    logic [7:0]  last_data = 8'h00;
    logic        prev_valid = 1'b0;
    logic [8:0]  got_b [$];
    logic [17:0] got_w [$];

    always @(negedge clk) begin
        if (byte_valid_o) begin
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_width got 2+ cycles want 1");
            end
            n_valid++;
            last_byte = byte_o;
            last_isd  = byte_is_data_o;
            got_b.push_back({byte_is_data_o, byte_o});
        end
        if (fb_we_o) begin
            checks++;
            if (!byte_valid_o) begin
                errors++;
                $display("FAIL we_with_valid got valid 0 want 1");
            end
            n_we++;
            last_addr = fb_addr_o;
            last_data = fb_data_o;
            got_w.push_back({fb_addr_o, fb_data_o});
        end
        prev_valid = byte_valid_o;
    end

    // Behavioural panel model
    int          m_page, m_col;
    logic        m_disp;
    logic [7:0]  m_fb [COLS*4];
    bit          m_wr [COLS*4];
    logic [8:0]  exp_b [$];
    logic [17:0] exp_w [$];

    function automatic void model_reset();
        m_page = 0;
        m_col  = 0;
        m_disp = 1'b0;
        for (int k = 0; k < COLS*4; k++) m_wr[k] = 1'b0;
        exp_b.delete();
        exp_w.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic a);
        exp_b.push_back({a, b});
        if (a) begin
            if (m_col < COLS) begin
                exp_w.push_back({2'(m_page), 8'(m_col), b});
                m_fb[m_page*COLS + m_col] = b;
                m_wr[m_page*COLS + m_col] = 1'b1;
            end
            m_col = (m_col == COLS-1) ? 0 : (m_col + 1) % 256;
        end else if (b >= 8'hB0 && b <= 8'hB3) begin
            m_page = int'(b) - 'hB0;
        end else if (b >= 8'h10 && b <= 8'h1F) begin
            m_col = (m_col % 16) + 16 * (int'(b) - 'h10);
        end else if (b <= 8'h0F) begin
            m_col = (m_col / 16) * 16 + int'(b);
        end else if (b == 8'hAF) begin
            m_disp = 1'b1;
        end else if (b == 8'hAE) begin
            m_disp = 1'b0;
        end
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic a, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sdi = b[i];
            a0  = a;
            sck = 1'b0;
            wait_clk(hp_lo);
            sck = 1'b1;
            wait_clk(hp_hi);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic a);
        send_bits(b, a, 8);
        sck = 1'b0;
        wait_clk(4);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte"}, 32'(byte_o), 32'h0);
        chk({tag, "_isdata"}, 32'(byte_is_data_o), 32'h0);
        chk({tag, "_valid"}, 32'(byte_valid_o), 32'h0);
        chk({tag, "_we"}, 32'(fb_we_o), 32'h0);
        chk({tag, "_addr"}, 32'(fb_addr_o), 32'h0);
        chk({tag, "_data"}, 32'(fb_data_o), 32'h0);
        chk({tag, "_on"}, 32'(disp_on_o), 32'h0);
        chk({tag, "_rd"}, 32'(rd_data_o), 32'h0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       a;
        logic       exp_we;
        logic [9:0] exp_addr;
        logic       exp_on;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int nv0, nw0, cnt, r;
        logic [7:0] rb;
        logic       ra;
        logic [7:0] rexp;

        vecs.push_back('{8'hB2, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h11, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h04, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h3C, 1'b1, 1'b1, {2'd2, 8'd20}, 1'b0});
        vecs.push_back('{8'h77, 1'b1, 1'b1, {2'd2, 8'd21}, 1'b0});
        vecs.push_back('{8'hB1, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h18, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h03, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h01, 1'b1, 1'b1, {2'd1, 8'd131}, 1'b0});
        vecs.push_back('{8'h02, 1'b1, 1'b1, {2'd1, 8'd0}, 1'b0});
        vecs.push_back('{8'hAF, 1'b0, 1'b0, 10'd0, 1'b1});
        vecs.push_back('{8'hE2, 1'b0, 1'b0, 10'd0, 1'b1});
        vecs.push_back('{8'hAE, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h1F, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h0F, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h55, 1'b1, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h66, 1'b1, 1'b1, {2'd1, 8'd0}, 1'b0});
        vecs.push_back('{8'hB4, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h0A, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h44, 1'b1, 1'b1, {2'd1, 8'd10}, 1'b0});
        vecs.push_back('{8'hB3, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h10, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h07, 1'b0, 1'b0, 10'd0, 1'b0});
        vecs.push_back('{8'h5A, 1'b1, 1'b1, {2'd3, 8'd7}, 1'b0});

        rst = 1'b1; cs_n = 1'b1; res_n = 1'b1; sdi = 1'b0; a0 = 1'b0; sck = 1'b0; rd_addr = 10'd0;
        wait_clk(3);
        chk_reset_vals("rst_hold");
        rst = 1'b0;
        wait_clk(2);
        chk_reset_vals("rst_rel");
        cs_n = 1'b0;
        wait_clk(4);

        // Reset mid-byte, then one byte with the latency measured edge by edge
        send_byte(8'hAF, 1'b0);
        send_byte(8'h3C, 1'b1);
        chk("pre_on", 32'(disp_on_o), 32'h1);
        send_bits(8'hFF, 1'b1, 5);
        rst = 1'b1;
        wait_clk(2);
        chk_reset_vals("rst_mid");
        sck = 1'b0;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(4);
        nv0 = n_valid;
        send_bits(8'hA5, 1'b1, 7);
        sdi = 1'b1; a0 = 1'b1; sck = 1'b0;
        wait_clk(4);
        sck = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e2_valid", 32'(byte_valid_o), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e3_valid", 32'(byte_valid_o), 32'h1);
        chk("lat_e3_we", 32'(fb_we_o), 32'h1);
        chk("lat_byte", 32'(byte_o), 32'hA5);
        chk("lat_addr", 32'(fb_addr_o), 32'h0);
        chk("lat_data", 32'(fb_data_o), 32'hA5);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e4_valid", 32'(byte_valid_o), 32'h0);
        chk("lat_e4_we", 32'(fb_we_o), 32'h0);
        wait_clk(1);
        sck = 1'b0;
        wait_clk(4);
        chk("rst_one_strobe", 32'(n_valid - nv0), 32'h1);

        // CS abort after 4 bits
        nv0 = n_valid;
        send_bits(8'hF0, 1'b0, 4);
        sck = 1'b0;
        wait_clk(3);
        cs_n = 1'b1;
        wait_clk(6);
        cs_n = 1'b0;
        wait_clk(6);
        send_byte(8'h81, 1'b0);
        chk("abort_strobes", 32'(n_valid - nv0), 32'h1);
        chk("abort_byte", 32'(last_byte), 32'h81);

        // Display reset mid-byte clears addressing and display-on
        send_byte(8'hB3, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'hAF, 1'b0);
        chk("dres_on_before", 32'(disp_on_o), 32'h1);
        nv0 = n_valid;
        send_bits(8'hFF, 1'b1, 3);
        sck = 1'b0;
        wait_clk(2);
        res_n = 1'b0;
        wait_clk(10);
        chk("dres_on", 32'(disp_on_o), 32'h0);
        chk("dres_no_strobe", 32'(n_valid - nv0), 32'h0);
        res_n = 1'b1;
        wait_clk(6);
        nw0 = n_we;
        send_byte(8'h99, 1'b1);
        chk("dres_strobes", 32'(n_valid - nv0), 32'h1);
        chk("dres_we", 32'(n_we - nw0), 32'h1);
        chk("dres_addr", 32'(last_addr), 32'h0);
        chk("dres_data", 32'(last_data), 32'h99);

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            nv0 = n_valid;
            nw0 = n_we;
            send_byte(vecs[i].b, vecs[i].a);
            chk($sformatf("vec%0d_strobe", i), 32'(n_valid - nv0), 32'h1);
            chk($sformatf("vec%0d_byte", i), 32'(last_byte), 32'(vecs[i].b));
            chk($sformatf("vec%0d_isdata", i), 32'(last_isd), 32'(vecs[i].a));
            chk($sformatf("vec%0d_we", i), 32'(n_we - nw0), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_addr", i), 32'(last_addr), 32'(vecs[i].exp_addr));
                chk($sformatf("vec%0d_data", i), 32'(last_data), 32'(vecs[i].b));
            end
            chk($sformatf("vec%0d_on", i), 32'(disp_on_o), 32'(vecs[i].exp_on));
        end

        // Readback of directed writes
        rd_addr = {2'd3, 8'd7};
        wait_clk(1);
`ifdef DOGM132_RX_READBACK_EN
        chk("rd_3_7", 32'(rd_data_o), 32'h5A);
`else
        chk("rd_3_7", 32'(rd_data_o), 32'h00);
`endif
        rd_addr = {2'd1, 8'd131};
        wait_clk(1);
`ifdef DOGM132_RX_READBACK_EN
        chk("rd_1_131", 32'(rd_data_o), 32'h01);
`else
        chk("rd_1_131", 32'(rd_data_o), 32'h00);
`endif
        rd_addr = {2'd1, 8'd200};
        wait_clk(1);
        chk("rd_oob", 32'(rd_data_o), 32'h00);

        // Randomized stream against the model
        res_n = 1'b0;
        wait_clk(6);
        res_n = 1'b1;
        wait_clk(6);
        model_reset();
        got_b.delete();
        got_w.delete();
        for (int n = 0; n < 60; n++) begin
            hp_lo = $urandom_range(3, 6);
            hp_hi = $urandom_range(3, 6);
            r = $urandom_range(0, 9);
            ra = 1'b0;
            if (r <= 5) begin
                rb = 8'($urandom);
                ra = 1'b1;
            end else if (r == 6) begin
                rb = 8'hB0 | 8'($urandom_range(0, 15));
            end else if (r == 7) begin
                rb = 8'h10 | 8'($urandom_range(0, 8));
            end else if (r == 8) begin
                rb = 8'($urandom_range(0, 15));
            end else begin
                rb = ($urandom_range(0, 2) == 0) ? 8'hAF : (($urandom_range(0, 1) == 0) ? 8'hAE : 8'($urandom));
            end
            model_byte(rb, ra);
            send_byte(rb, ra);
            chk($sformatf("rand%0d_on", n), 32'(disp_on_o), 32'(m_disp));
        end
        hp_lo = 4;
        hp_hi = 4;
        chk("rand_nbytes", 32'(got_b.size()), 32'(exp_b.size()));
        chk("rand_nwrites", 32'(got_w.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
            chk($sformatf("rand_byte%0d", i), 32'(got_b[i]), 32'(exp_b[i]));
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
            chk($sformatf("rand_wr%0d", i), 32'(got_w[i]), 32'(exp_w[i]));

        cnt = 0;
        for (int k = 0; k < COLS*4 && cnt < 25; k++) begin
            if (m_wr[k]) begin
                rd_addr = {2'(k / COLS), 8'(k % COLS)};
                wait_clk(1);
`ifdef DOGM132_RX_READBACK_EN
                rexp = m_fb[k];
`else
                rexp = 8'h00;
`endif
                chk($sformatf("rand_rd%0d", k), 32'(rd_data_o), 32'(rexp));
                cnt++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dogm132_spi_rx.md
# dogm132_spi_rx

Receive-side model of the DOGM132 (ST7565R-class) serial display interface, i.e. the reader at the far end of the display driver's write-only SPI link. It oversamples CS/SCK/SI/A0/RES with the system clock, deserialises bytes, and decodes the page/column/display-on commands. Data bytes become frame-buffer writes for a 132x32 mirror of the panel. It sits beside the display controller in the top entity (for debug readback) or in the bench as a checking model.

## Interface
Parameters:
- COLS, 132, columns per page; column counter width 8 bits
- PAGES, 4, pages of 8 rows; page counter width 2 bits

Ports:
- clk_in  input  1  system clock; all logic on rising edge
- reset_in  input  1  asynchronous, active-high reset
- disp_cs_n_i  input  1  chip select, active low, asynchronous to clk_in
- disp_res_n_i  input  1  display reset, active low, asynchronous
- disp_data_i  input  1  serial data (SI), MSB first
- disp_addr_i  input  1  A0: 1 = display data, 0 = command
- disp_sck_i  input  1  serial clock; data sampled on rising edge
- byte_o  output  8  last received byte
- byte_is_data_o  output  1  A0 value latched with byte_o
- byte_valid_o  output  1  one-cycle strobe, new byte_o
- fb_we_o  output  1  one-cycle frame-buffer write strobe
- fb_addr_o  output  10  {page[1:0], column[7:0]} of the write
- fb_data_o  output  8  byte written (bit0 = top row of page)
- disp_on_o  output  1  display-on state (0xAF/0xAE)
- rd_addr_i  input  10  readback address {page, column}
- rd_data_o  output  8  readback data

## Operation
- Input sync: 2-flop synchroniser per SPI input, plus a third SCK stage for edge detect; rise = sck_s2 & ~sck_s3.
- Shift: on rise with cs_s2 = 0, shift_reg <= {shift_reg[6:0], data_s2}, bit_cnt += 1.
- Byte complete: on the 8th rise, latch byte_o and byte_is_data_o (A0 = addr_s2 at that rise), pulse byte_valid_o, bit_cnt -> 0.
- cs_s2 = 1: bit_cnt cleared; partial byte discarded, no strobe. SCK edges while deselected are ignored.
- Command decode (byte_is_data = 0):
  - 0xB0-0xB3: page <= byte[1:0].
  - 0xB4-0xBF: ignored.
  - 0x10-0x1F: col[7:4] <= byte[3:0].
  - 0x00-0x0F: col[3:0] <= byte[3:0].
  - 0xAF: disp_on_o <= 1.
  - 0xAE: disp_on_o <= 0.
  - All others: no effect beyond byte_valid_o.
- Data byte: fb_we_o = 1, fb_addr_o = {page, col}, fb_data_o = byte; then col += 1.
  - Column COLS-1 wraps to 0; page unchanged.
  - A data write with col >= COLS (set via command) is suppressed (no fb_we_o); col still increments, wrapping 255 -> 0.
- disp_res_s2 = 0: page, col, bit_cnt, disp_on_o cleared; partial byte discarded; no strobes while low. Frame-buffer contents are kept.
- reset_in: everything below cleared, including synchroniser flops (SCK history = 0, CS = 1, RES = 1).

## Timing
- Reset values: byte_o = 0x00, byte_is_data_o = 0, byte_valid_o = 0, fb_we_o = 0, fb_addr_o = 0, fb_data_o = 0, disp_on_o = 0, rd_data_o = 0x00.
- Latency: byte_valid_o and fb_we_o rise after the 3rd clk_in edge following the first edge that samples the 8th SCK high. Both are high for exactly 1 cycle.
- Command effects (page/col/disp_on_o) are visible in the same cycle as byte_valid_o.
- SCK high and low times must each be >= 3 clk_in periods. SI, A0 and CS must be stable >= 3 periods around the SCK rise. Faster SCK is unsupported.
- Back-to-back bytes need no gap; CS may stay low across bytes.
- Readback: synchronous, 1-cycle latency. A same-cycle write and read of one address returns old data.

## Configuration
- DOGM132_RX_READBACK_EN defined: internal COLS x PAGES x 8-bit frame buffer (528 bytes), written by fb_we_o. rd_addr_i/rd_data_o are live; rd_addr_i with column >= COLS returns 0x00.
- Undefined: no frame-buffer memory. rd_data_o is tied to 0x00 and rd_addr_i is ignored. All stream outputs (byte_*, fb_*, disp_on_o) are unchanged.

## Test plan
- Reset: assert reset_in mid-byte (after 5 bits) -> all outputs at reset values; the next full byte 0xA5 gives byte_o = 0xA5 with exactly one byte_valid_o.
- Commands 0xB2, 0x11, 0x04 (A0 = 0), then data 0x3C (A0 = 1) -> fb_we_o pulse with fb_addr_o = {2'd2, 8'd20}, fb_data_o = 0x3C. Next data byte goes to column 21.
- Wrap: set page 1, col 131, write 0x01, 0x02 -> writes at {1,131} and {1,0}; page stays 1.
- Abort: CS high after 4 bits, then a full byte 0x81 -> single strobe with byte_o = 0x81. disp_res_n_i low mid-byte -> no strobe, page/col = 0, disp_on_o = 0.
- Display on/off: 0xAF -> disp_on_o = 1; 0xAE -> 0. Unknown command 0xE2 -> byte_valid_o only, no state change.
- Readback (macro defined): write 0x5A at {3,7}, then rd_addr_i = {3,7} -> rd_data_o = 0x5A one cycle later. Macro undefined -> rd_data_o = 0x00.
